// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default frame geometry and
// tick-counter sizing, used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned UART_DBITS   = 8;
    localparam int unsigned UART_OS_TICK = 16;
    localparam int unsigned UART_SB_TICK = 16;

    // Width needed to hold max(os_tick, sb_tick)-1.
    function automatic int unsigned tick_width(input int unsigned os_tick,
                                               input int unsigned sb_tick);
        int unsigned m;
        m = (os_tick > sb_tick) ? os_tick : sb_tick;
        return (m > 2) ? int'($clog2(m)) : 1;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side handshake of the UART transmitter: start request, data byte,
// busy status and completion pulse.
interface uart_transmitter_if #(
    parameter int unsigned DBITS = uart_pkg::UART_DBITS
);
    logic             tx_start;
    logic [DBITS-1:0] d_in;
    logic             tx_busy;
    logic             done_tick;

    modport master (
        output tx_start,
        output d_in,
        input  tx_busy,
        input  done_tick
    );

    modport slave (
        input  tx_start,
        input  d_in,
        output tx_busy,
        output done_tick
    );
endinterface

// File: rtl/uart_tick_counter.sv
// Modulo counter advanced by baud_tick, with synchronous clear and a
// terminal-count compare; wraps to zero on the tick that hits the terminal.
module uart_tick_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic             at_term
);
    logic [WIDTH-1:0] count;

    assign at_term = (count == term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (tick) begin
            count <= at_term ? '0 : count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DBITS data bits LSB-first, optional even parity
// (UART_TX_PARITY_EN), stop period; tx is registered from the next-state level.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned DBITS   = UART_DBITS,
    parameter int unsigned OS_TICK = UART_OS_TICK,
    parameter int unsigned SB_TICK = UART_SB_TICK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    uart_transmitter_if.slave host,
    output logic              tx
);
    localparam int unsigned   SW      = tick_width(OS_TICK, SB_TICK);
    localparam int unsigned   NW      = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [SW-1:0] OS_LAST = SW'(OS_TICK - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBITS - 1);

    uart_state_t      state_q, state_d;
    logic [DBITS-1:0] b_q, b_d;
    logic [NW-1:0]    n_q, n_d;
    logic [SW-1:0]    s_term;
    logic             s_clr, s_at_term, bit_end;
    logic             tx_d, done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    // Counter is held clear in IDLE and wraps itself at each bit boundary.
    assign s_clr   = (state_q == IDLE);
    assign s_term  = (state_q == STOP) ? SB_LAST : OS_LAST;
    assign bit_end = baud_tick && s_at_term;

    uart_tick_counter #(.WIDTH(SW)) u_tick_counter (
        .clk     (clk),
        .rst     (rst),
        .tick    (baud_tick),
        .clr     (s_clr),
        .term    (s_term),
        .at_term (s_at_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            b_q     <= '0;
            n_q     <= '0;
            tx      <= 1'b1;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            n_q     <= n_d;
            tx      <= tx_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        n_d     = n_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (host.tx_start) begin
                    state_d = START;
                    b_d     = host.d_in;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^host.d_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    n_d     = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    b_d = b_q >> 1;
                    if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the next state so the pad register changes with it.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
        done_d       = (state_q == STOP) && bit_end;
        host.tx_busy = (state_q != IDLE);
    end

    assign host.done_tick = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized bench for uart_transmitter: two instances (SB_TICK 16 and 32)
// checked cycle by cycle against a tick-count model of the frame.
module tb_uart_transmitter;
    localparam int unsigned DB = 8;
    localparam int unsigned OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic baud_tick = 1'b0;
    logic tx_a, tx_b;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned last_lat = 0;

    uart_transmitter_if #(.DBITS(DB)) bus_a ();
    uart_transmitter_if #(.DBITS(DB)) bus_b ();

    uart_transmitter #(.DBITS(DB), .OS_TICK(OS), .SB_TICK(16)) dut_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .host(bus_a), .tx(tx_a)
    );
    uart_transmitter #(.DBITS(DB), .OS_TICK(OS), .SB_TICK(32)) dut_b (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .host(bus_b), .tx(tx_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input bit sel, input logic start, input logic [7:0] data);
        if (sel) begin
            bus_b.tx_start = start;
            bus_b.d_in     = data;
        end else begin
            bus_a.tx_start = start;
            bus_a.d_in     = data;
        end
    endtask

    function automatic logic [2:0] observe(input bit sel);
        return sel ? {tx_b, bus_b.tx_busy, bus_b.done_tick}
                   : {tx_a, bus_a.tx_busy, bus_a.done_tick};
    endfunction

    function automatic logic tick_gen(input int unsigned mode, input int unsigned c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0);
            default: return ($urandom_range(0, 2) == 0);
        endcase
    endfunction

    // Expected line level after k baud ticks of a frame carrying 'data'.
    function automatic logic exp_line(input logic [7:0] data, input int unsigned k);
        int unsigned idx;
        if (k < OS) return 1'b0;
        idx = k / OS - 1;
        if (idx < DB) return data[idx];
        if (PAR == 1 && idx == DB) return ^data;
        return 1'b1;
    endfunction

    task automatic send_frame(input bit sel, input logic [7:0] data, input int unsigned mode,
                              input bit hold, input bit chain_next,
                              input logic [7:0] next_data, input bit chained);
        int unsigned total, ticks;
        bit is_done, finished;
        logic [2:0] exp;
        total = (1 + DB + PAR) * OS + (sel ? 32 : 16);
        ticks = 0;
        finished = 0;
        if (!chained) begin
            @(posedge clk); #1;
            drive(sel, 1'b1, data);
            baud_tick = tick_gen(mode, 0);
        end
        for (int unsigned c = 1; c <= 4000 && !finished; c++) begin
            @(posedge clk); #1;
            is_done = (ticks == total);
            if (is_done) drive(sel, chain_next, chain_next ? next_data : 8'($urandom));
            else         drive(sel, hold, 8'($urandom));
            baud_tick = tick_gen(mode, c);
            @(negedge clk);
            exp = {exp_line(data, ticks), ticks < total, is_done};
            chk(sel ? "frame_b" : "frame_a", 32'(observe(sel)), 32'(exp));
            if (baud_tick) ticks++;
            if (is_done) begin
                finished = 1;
                last_lat = c;
            end
        end
        if (!finished) chk("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_check(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 8'($urandom));
            drive(1'b1, 1'b0, 8'($urandom));
            baud_tick = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_a", 32'(observe(1'b0)), 32'b100);
            chk("idle_b", 32'(observe(1'b1)), 32'b100);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", 32'(observe(1'b0)), 32'b100);
        chk("reset_b", 32'(observe(1'b1)), 32'b100);
        @(negedge clk);
        rst = 1'b1;
        idle_check(3);

        send_frame(1'b0, 8'hA5, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("lat_a5", last_lat, 161 + 16 * PAR);
        idle_check(2);

        send_frame(1'b0, 8'h00, 1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("lat_tick4", last_lat, 4 * ((1 + DB + PAR) * OS + 16) + 1);

        send_frame(1'b0, 8'h3C, 0, 1'b1, 1'b1, 8'hC3, 1'b0);
        chk("lat_b2b_1", last_lat, 161 + 16 * PAR);
        send_frame(1'b0, 8'hC3, 0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("lat_b2b_2", last_lat, 161 + 16 * PAR);
        idle_check(40);

        send_frame(1'b1, 8'hA5, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("lat_sb32", last_lat, 177 + 16 * PAR);
        idle_check(2);

        send_frame(1'b0, 8'h07, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        send_frame(1'b0, 8'h03, 0, 1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 16; i++) begin
            send_frame(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2),
                       1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
            idle_check($urandom_range(0, 3));
        end

        // Abandon a frame in the middle of its data bits.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 8'h5A);
        baud_tick = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h00);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid", 32'(observe(1'b0)), 32'b100);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", 32'(observe(1'b0)), 32'b100);
        end
        rst = 1'b1;
        idle_check(4);
        send_frame(1'b0, 8'h96, 0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("lat_after_rst", last_lat, 161 + 16 * PAR);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter that converts a parallel byte into an asynchronous frame: one start bit, DBITS data bits LSB-first, and a stop period. It shares the oversampled `baud_tick` strobe with the UART receiver, so each bit lasts a fixed number of ticks. It sits between the host-side data path and the `tx` pad, and reports completion with a one-cycle pulse.

## Interface
- `DBITS`, 8: number of data bits per frame (5–9).
- `OS_TICK`, 16: baud_ticks per start/data bit.
- `SB_TICK`, 16: baud_ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `baud_tick`  in  1  one-cycle strobe at OS_TICK × baud rate.
- `tx_start`  in  1  request to send `d_in`; sampled only in IDLE.
- `d_in`  in  DBITS  data to send; captured in the cycle `tx_start` is accepted.
- `tx`  out  1  serial line, registered; idles high.
- `tx_busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `done_tick`  out  1  one-cycle pulse when the frame completes.

## Operation
- FSM states: IDLE, START, DATA, (PARITY), STOP. Tick counter `s` counts baud_ticks within a bit. Bit counter `n` has width $clog2(DBITS).
- IDLE: `tx`=1. On `tx_start`=1:
  - latch `d_in` into shift register `b`;
  - clear `s`;
  - go to START.
  - `tx_start` is ignored in every other state, and `d_in` changes mid-frame have no effect.
- START: `tx`=0. On a baud_tick with `s`==OS_TICK-1: clear `s` and `n`, go to DATA. On any other baud_tick: increment `s`.
- DATA: `tx`=`b[0]`. On a baud_tick with `s`==OS_TICK-1:
  - clear `s`;
  - shift `b` right by one;
  - if `n`==DBITS-1, go to STOP (or PARITY); otherwise increment `n`.
- STOP: `tx`=1. On a baud_tick with `s`==SB_TICK-1: go to IDLE and pulse `done_tick`.
- Counters advance only on `baud_tick`. Between ticks, all state holds.
- `tx` comes from a register loaded with the next-state line value, so there is no combinational glitch on the pad.
- Reset (at any time, including mid-frame):
  - state=IDLE, `s`=0, `n`=0, `b`=0;
  - `tx`=1, `tx_busy`=0, `done_tick`=0.
  - The partial frame is abandoned; no `done_tick` is issued for it.
- The `s` width covers max(OS_TICK, SB_TICK)-1. Counter comparisons are exact-equality checks, with no wrap-around reliance.

## Timing
- Let T be the cycle in which `tx_start` is sampled high in IDLE.
- `tx_busy` is high from T+1. `tx` goes low at T+1.
- Each start/data bit lasts exactly OS_TICK baud_ticks. The stop period lasts SB_TICK baud_ticks.
- `done_tick` and the IDLE transition are registered, in the cycle after the final stop tick. In that same cycle, `tx_busy`=0, and a new `tx_start` is accepted. Back-to-back frames therefore have no idle gap beyond the stop period.
- `done_tick` is high for exactly one clk cycle per completed frame.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - adds a PARITY state between DATA and STOP, lasting OS_TICK ticks;
  - `tx` = XOR of the captured data, which is even parity;
  - `b` keeps an unshifted copy, or a running parity flop toggled at each data-bit shift.
- Not defined: DATA goes directly to STOP, and no parity logic is synthesised.
- The receiver must be built with the matching setting.

## Structure
- Shared package `uart_pkg`:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - default DBITS/OS_TICK/SB_TICK localparams, also used by the receiver.
- One natural sub-module, `uart_tick_counter`: modulo counter advanced by `baud_tick`, with clear and terminal-count compare. It is reusable by the receiver. All other logic stays in `uart_transmitter`.

## Test plan
- Reset mid-frame: assert `rst`=0 during DATA → `tx`=1, `tx_busy`=0 immediately. No `done_tick` is issued. The next `tx_start` sends a clean frame.
- `baud_tick` tied high, DBITS=8, send 0xA5 at T:
  - `tx`=0 for T+1..T+16;
  - then bits 1,0,1,0,0,1,0,1, 16 cycles each;
  - `tx`=1 for T+145..T+160;
  - `done_tick` high only at T+161.
- `baud_tick` every 4th cycle, send 0x00 → every bit lasts 64 cycles, and the frame is 640 cycles to `done_tick`.
- `tx_start` held high continuously, sending 0x3C then 0xC3 (changing `d_in` mid-frame) → exactly two frames. The second frame starts at the `done_tick` cycle plus 1, and carries the `d_in` value present at its acceptance cycle.
- SB_TICK=32 → the stop high period is 32 ticks, and `done_tick` comes correspondingly later.
- `UART_TX_PARITY_EN`, send 0x07 → parity bit 1 appears after bit 7, and the frame lasts 11×16 ticks. Send 0x03 → parity bit 0.
